// File: rtl/mc_control_ws_if.sv
// mc_control_ws_if: the opcode and memory handshake going into the main control FSM,
// and the datapath controls and status coming out of it.
interface mc_control_ws_if #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
);
    logic [OP_W-1:0]  op;
    logic             memReady;
    logic             pcWrite, pcWriteCond, branchNe, IorD, memRead, memWrite, irWrite;
    logic [1:0]       memToReg, regDst;
    logic             regWrite, aluSrcA;
    logic [1:0]       aluSrcB;
    logic [2:0]       aluOp;
    logic [1:0]       pcSource;
    logic             illegalOp, instrDone, fault;
    logic [3:0]       state;
    logic [CNT_W-1:0] cycleCount, instrCount;

    modport master (
        input  op, memReady,
        output pcWrite, pcWriteCond, branchNe, IorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
               illegalOp, instrDone, fault, state, cycleCount, instrCount
    );

    modport slave (
        output op, memReady,
        input  pcWrite, pcWriteCond, branchNe, IorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
               illegalOp, instrDone, fault, state, cycleCount, instrCount
    );
endinterface

// File: rtl/mc_control_ws.sv
// mc_control_ws: multicycle MIPS main control FSM with memory wait states and a timeout fault.
// Defining CTRL_PERF_EN adds the cycle and retired-instruction counters.
module mc_control_ws #(
    parameter int OP_W      = 6,
    parameter int TIMEOUT_W = 4,
    parameter int CNT_W     = 32
) (
    input logic            clk,
    input logic            resetN,
    mc_control_ws_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADDR = 4'd2,
        MEMRD   = 4'd3,
        MEMRDWB = 4'd4,
        MEMWR   = 4'd5,
        REXEC   = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        JAL     = 4'd10,
        IMMEXEC = 4'd11,
        IMMWB   = 4'd12,
        FAULT   = 4'd15
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(43);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
    localparam logic [OP_W-1:0] OP_ANDI = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(10);
    // Last count value from which one more stalled cycle exhausts the wait budget.
    localparam logic [TIMEOUT_W-1:0] W_LAST = TIMEOUT_W'(2 ** TIMEOUT_W - 2);

    state_t               r_state, w_next;
    logic [TIMEOUT_W-1:0] r_wait;
    logic                 w_stall;
    logic [2:0]           w_imm_alu;

    assign w_stall   = (r_state == FETCH || r_state == MEMRD || r_state == MEMWR) && !bus.memReady;
    assign w_imm_alu = bus.op == OP_ANDI ? 3'b011 :
                       bus.op == OP_ORI  ? 3'b100 :
                       bus.op == OP_SLTI ? 3'b101 : 3'b000;
    assign bus.state = r_state;
    assign bus.fault = r_state == FAULT;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_stall && w_next == r_state) ? r_wait + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        {bus.pcWrite, bus.pcWriteCond, bus.branchNe, bus.IorD, bus.memRead, bus.memWrite,
         bus.irWrite, bus.memToReg, bus.regDst, bus.regWrite, bus.aluSrcA, bus.aluSrcB,
         bus.aluOp, bus.pcSource, bus.illegalOp, bus.instrDone} = '0;
        case (r_state)
            FETCH: begin
                bus.memRead = 1'b1;
                bus.aluSrcB = 2'b01;
                bus.pcWrite = bus.memReady;
                bus.irWrite = bus.memReady;
                w_next      = bus.memReady ? DECODE : FETCH;
            end
            DECODE: begin
                bus.aluSrcB = 2'b11;
                case (bus.op)
                    OP_R:                             w_next = REXEC;
                    OP_LW, OP_SW:                     w_next = MEMADDR;
                    OP_BEQ, OP_BNE:                   w_next = BRANCH;
                    OP_J:                             w_next = JUMP;
                    OP_JAL:                           w_next = JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = IMMEXEC;
                    default: begin
                        w_next        = FETCH;
                        bus.illegalOp = 1'b1;
                    end
                endcase
            end
            MEMADDR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                w_next      = bus.op == OP_LW ? MEMRD : bus.op == OP_SW ? MEMWR : FETCH;
            end
            MEMRD: begin
                bus.IorD    = 1'b1;
                bus.memRead = 1'b1;
                w_next      = bus.memReady ? MEMRDWB : MEMRD;
            end
            MEMRDWB: begin
                bus.regWrite  = 1'b1;
                bus.memToReg  = 2'b01;
                bus.instrDone = 1'b1;
                w_next        = FETCH;
            end
            MEMWR: begin
                bus.IorD      = 1'b1;
                bus.memWrite  = 1'b1;
                bus.instrDone = bus.memReady;
                w_next        = bus.memReady ? FETCH : MEMWR;
            end
            REXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = 3'b010;
                w_next      = RWB;
            end
            RWB: begin
                bus.regDst    = 2'b01;
                bus.regWrite  = 1'b1;
                bus.instrDone = 1'b1;
                w_next        = FETCH;
            end
            BRANCH: begin
                bus.aluSrcA     = 1'b1;
                bus.aluOp       = 3'b001;
                bus.pcWriteCond = 1'b1;
                bus.pcSource    = 2'b01;
                bus.branchNe    = bus.op == OP_BNE;
                bus.instrDone   = 1'b1;
                w_next          = FETCH;
            end
            JUMP: begin
                bus.pcWrite   = 1'b1;
                bus.pcSource  = 2'b10;
                bus.instrDone = 1'b1;
                w_next        = FETCH;
            end
            JAL: begin
                bus.pcWrite   = 1'b1;
                bus.pcSource  = 2'b10;
                bus.regWrite  = 1'b1;
                bus.regDst    = 2'b10;
                bus.memToReg  = 2'b10;
                bus.instrDone = 1'b1;
                w_next        = FETCH;
            end
            IMMEXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                bus.aluOp   = w_imm_alu;
                w_next      = IMMWB;
            end
            IMMWB: begin
                bus.regWrite  = 1'b1;
                bus.aluOp     = w_imm_alu;
                bus.instrDone = 1'b1;
                w_next        = FETCH;
            end
            FAULT:   w_next = FAULT;
            default: w_next = FETCH;
        endcase
        // memReady on the terminal-count cycle leaves w_stall low, so the normal transition wins.
        if (w_stall && r_wait == W_LAST)
            w_next = FAULT;
        if (!resetN)
            {bus.pcWrite, bus.pcWriteCond, bus.branchNe, bus.IorD, bus.memRead, bus.memWrite,
             bus.irWrite, bus.memToReg, bus.regDst, bus.regWrite, bus.aluSrcA, bus.aluSrcB,
             bus.aluOp, bus.pcSource, bus.illegalOp, bus.instrDone} = '0;
    end

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] r_cycles, r_instrs;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_cycles <= '0;
            r_instrs <= '0;
        end else begin
            r_cycles <= r_cycles + 1'b1;
            if (bus.instrDone)
                r_instrs <= r_instrs + 1'b1;
        end
    end

    assign bus.cycleCount = r_cycles;
    assign bus.instrCount = r_instrs;
`else
    assign bus.cycleCount = '0;
    assign bus.instrCount = '0;
`endif
endmodule

// File: tb/tb_mc_control_ws.sv
// tb_mc_control_ws: directed and randomized checks of the multicycle main control FSM
// against a table-driven reference of per-state controls and per-opcode state paths.
module tb_mc_control_ws;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int total = 0;
    int bad = 0;
    logic [21:0] act;

    mc_control_ws_if #(.OP_W(6), .CNT_W(4)) ifc();
    mc_control_ws #(.OP_W(6), .TIMEOUT_W(4), .CNT_W(4)) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(ifc.master)
    );

    always #5 clk = ~clk;

    assign act = {ifc.pcWrite, ifc.pcWriteCond, ifc.branchNe, ifc.IorD, ifc.memRead, ifc.memWrite,
                  ifc.irWrite, ifc.memToReg, ifc.regDst, ifc.regWrite, ifc.aluSrcA, ifc.aluSrcB,
                  ifc.aluOp, ifc.pcSource, ifc.illegalOp, ifc.instrDone};

    function automatic logic legal(logic [5:0] o);
        return o inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3, 6'd8, 6'd12, 6'd13, 6'd10};
    endfunction

    function automatic logic [3:0] exp_cnt(int n);
`ifdef CTRL_PERF_EN
        return 4'(n);
`else
        return 4'(n * 0);
`endif
    endfunction

    // Control word each state must produce, packed in the same order as act; bit 0 is instrDone.
    function automatic logic [21:0] exp_ctrl(int st, logic [5:0] o, logic mr);
        logic pw, pwc, bne, iord, mrd, mwr, irw, rw, sa, ill, dn;
        logic [1:0] mtr, rd, sb, ps;
        logic [2:0] ao, ia;
        {pw, pwc, bne, iord, mrd, mwr, irw, rw, sa, ill, dn} = '0;
        {mtr, rd, sb, ps, ao} = '0;
        ia = o == 6'd12 ? 3'd3 : o == 6'd13 ? 3'd4 : o == 6'd10 ? 3'd5 : 3'd0;
        case (st)
            0: begin mrd = 1; sb = 2'd1; pw = mr; irw = mr; end
            1: begin sb = 2'd3; ill = !legal(o); end
            2: begin sa = 1; sb = 2'd2; end
            3: begin iord = 1; mrd = 1; end
            4: begin rw = 1; mtr = 2'd1; dn = 1; end
            5: begin iord = 1; mwr = 1; dn = mr; end
            6: begin sa = 1; ao = 3'd2; end
            7: begin rd = 2'd1; rw = 1; dn = 1; end
            8: begin sa = 1; ao = 3'd1; pwc = 1; ps = 2'd1; bne = o == 6'd5; dn = 1; end
            9: begin pw = 1; ps = 2'd2; dn = 1; end
            10: begin pw = 1; ps = 2'd2; rw = 1; rd = 2'd2; mtr = 2'd2; dn = 1; end
            11: begin sa = 1; sb = 2'd2; ao = ia; end
            12: begin rw = 1; ao = ia; dn = 1; end
            default: ;
        endcase
        return {pw, pwc, bne, iord, mrd, mwr, irw, mtr, rd, rw, sa, sb, ao, ps, ill, dn};
    endfunction

    task automatic set_in(input logic [5:0] o, input logic mr);
        ifc.op = o;
        ifc.memReady = mr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        resetN = 1'b0;
        set_in(6'd0, 1'b1);
        tick;
        tick;
        resetN = 1'b1;
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        set_in(6'd35, 1'b1);
        total++;
        if (act !== 22'd0) begin bad++; $display("FAIL reset_gate: got %h want 0", act); end
        tick;
        set_in(6'd0, 1'b1);
        total++;
        if (ifc.state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", ifc.state); end
        total++;
        if (ifc.fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", ifc.fault); end
        total++;
        if (ifc.cycleCount !== 4'd0 || ifc.instrCount !== 4'd0) begin
            bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", ifc.cycleCount, ifc.instrCount);
        end
        resetN = 1'b1;
    endtask

    task automatic test_rtype;
        int exp_s[5] = '{0, 1, 6, 7, 0};
        int dn = 0;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            set_in(6'd0, 1'b1);
            total++;
            if (ifc.state !== 4'(exp_s[i])) begin bad++; $display("FAIL rtype_state%0d: got %0d want %0d", i, ifc.state, exp_s[i]); end
            if (i == 3) begin
                total++;
                if (ifc.regWrite !== 1'b1 || ifc.regDst !== 2'b01) begin
                    bad++; $display("FAIL rtype_rwb: got rw=%b rd=%b want 1/01", ifc.regWrite, ifc.regDst);
                end
            end
            if (i < 4) dn += int'(ifc.instrDone);
            tick;
        end
        total++;
        if (dn != 1) begin bad++; $display("FAIL rtype_done: got %0d pulses want 1", dn); end
    endtask

    task automatic test_lw_wait;
        int st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic mr[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        do_reset;
        for (int i = 0; i < 9; i++) begin
            set_in(6'd35, mr[i]);
            total++;
            if (ifc.state !== 4'(st[i])) begin bad++; $display("FAIL lw_state%0d: got %0d want %0d", i, ifc.state, st[i]); end
            if (st[i] == 3) begin
                total++;
                if (ifc.memRead !== 1'b1 || ifc.IorD !== 1'b1) begin
                    bad++; $display("FAIL lw_memrd%0d: got rd=%b iord=%b want 1/1", i, ifc.memRead, ifc.IorD);
                end
            end
            if (st[i] == 4) begin
                total++;
                if (ifc.memToReg !== 2'b01 || ifc.regWrite !== 1'b1) begin
                    bad++; $display("FAIL lw_wb: got mtr=%b rw=%b want 01/1", ifc.memToReg, ifc.regWrite);
                end
            end
            tick;
        end
    endtask

    task automatic test_branch;
        logic [5:0] o;
        for (int k = 0; k < 2; k++) begin
            o = k == 1 ? 6'd5 : 6'd4;
            do_reset;
            set_in(o, 1'b1);
            tick;
            set_in(o, 1'b1);
            tick;
            set_in(o, 1'b1);
            total++;
            if (ifc.state !== 4'd8 || ifc.pcWriteCond !== 1'b1 || ifc.branchNe !== 1'(k) ||
                ifc.aluOp !== 3'b001 || ifc.pcSource !== 2'b01) begin
                bad++; $display("FAIL branch_op%0d: got st=%0d pwc=%b bne=%b alu=%b ps=%b want 8/1/%0d/001/01",
                                o, ifc.state, ifc.pcWriteCond, ifc.branchNe, ifc.aluOp, ifc.pcSource, k);
            end
            tick;
        end
    endtask

    task automatic test_jal_imm;
        do_reset;
        set_in(6'd3, 1'b1);
        tick;
        set_in(6'd3, 1'b1);
        tick;
        set_in(6'd3, 1'b1);
        total++;
        if (ifc.state !== 4'd10 || ifc.pcWrite !== 1'b1 || ifc.regWrite !== 1'b1 ||
            ifc.regDst !== 2'b10 || ifc.memToReg !== 2'b10) begin
            bad++; $display("FAIL jal: got st=%0d pw=%b rw=%b rd=%b mtr=%b want 10/1/1/10/10",
                            ifc.state, ifc.pcWrite, ifc.regWrite, ifc.regDst, ifc.memToReg);
        end
        tick;
        set_in(6'd13, 1'b1);
        tick;
        set_in(6'd13, 1'b1);
        tick;
        set_in(6'd13, 1'b1);
        total++;
        if (ifc.state !== 4'd11 || ifc.aluOp !== 3'b100) begin
            bad++; $display("FAIL ori_exec: got st=%0d alu=%b want 11/100", ifc.state, ifc.aluOp);
        end
        tick;
        set_in(6'd13, 1'b1);
        total++;
        if (ifc.state !== 4'd12 || ifc.regWrite !== 1'b1 || ifc.aluOp !== 3'b100) begin
            bad++; $display("FAIL ori_wb: got st=%0d rw=%b alu=%b want 12/1/100", ifc.state, ifc.regWrite, ifc.aluOp);
        end
        tick;
    endtask

    task automatic test_illegal;
        do_reset;
        set_in(6'd63, 1'b1);
        tick;
        set_in(6'd63, 1'b1);
        total++;
        if (ifc.state !== 4'd1 || ifc.illegalOp !== 1'b1 || ifc.instrDone !== 1'b0) begin
            bad++; $display("FAIL illegal_decode: got st=%0d ill=%b dn=%b want 1/1/0", ifc.state, ifc.illegalOp, ifc.instrDone);
        end
        tick;
        set_in(6'd63, 1'b1);
        total++;
        if (ifc.state !== 4'd0 || ifc.illegalOp !== 1'b0 || ifc.instrCount !== exp_cnt(0)) begin
            bad++; $display("FAIL illegal_after: got st=%0d ill=%b ic=%0d want 0/0/%0d", ifc.state, ifc.illegalOp, ifc.instrCount, exp_cnt(0));
        end
    endtask

    task automatic test_timeout;
        do_reset;
        for (int i = 0; i < 15; i++) begin
            set_in(6'd0, 1'b0);
            total++;
            if (ifc.state !== 4'd0 || ifc.fault !== 1'b0) begin
                bad++; $display("FAIL timeout_stall%0d: got st=%0d f=%b want 0/0", i, ifc.state, ifc.fault);
            end
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            set_in(6'd0, 1'b1);
            total++;
            if (ifc.state !== 4'd15 || ifc.fault !== 1'b1 || act !== 22'd0) begin
                bad++; $display("FAIL fault_hold%0d: got st=%0d f=%b ctrl=%h want 15/1/0", i, ifc.state, ifc.fault, act);
            end
            tick;
        end
        set_in(6'd0, 1'b1);
        total++;
        if (ifc.cycleCount !== exp_cnt(18)) begin bad++; $display("FAIL fault_cycles: got %0d want %0d", ifc.cycleCount, exp_cnt(18)); end
        do_reset;
        total++;
        if (ifc.fault !== 1'b0 || ifc.state !== 4'd0) begin bad++; $display("FAIL fault_clear: got f=%b st=%0d want 0/0", ifc.fault, ifc.state); end
        for (int i = 0; i < 14; i++) begin
            set_in(6'd0, 1'b0);
            tick;
        end
        set_in(6'd0, 1'b1);
        total++;
        if (ifc.irWrite !== 1'b1) begin bad++; $display("FAIL terminal_ready: got irWrite=%b want 1", ifc.irWrite); end
        tick;
        set_in(6'd0, 1'b1);
        total++;
        if (ifc.state !== 4'd1 || ifc.fault !== 1'b0) begin
            bad++; $display("FAIL terminal_wins: got st=%0d f=%b want 1/0", ifc.state, ifc.fault);
        end
        tick;
    endtask

    task automatic test_wrap;
        do_reset;
        for (int n = 0; n < 20; n++)
            for (int c = 0; c < 4; c++) begin
                set_in(6'd0, 1'b1);
                tick;
            end
        set_in(6'd0, 1'b1);
        total++;
        if (ifc.instrCount !== exp_cnt(20) || ifc.cycleCount !== exp_cnt(80)) begin
            bad++; $display("FAIL wrap_cnt: got ic=%0d cc=%0d want %0d/%0d", ifc.instrCount, ifc.cycleCount, exp_cnt(20), exp_cnt(80));
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        for (int c = 0; c < 6; c++) begin
            set_in(6'd0, 1'b1);
            tick;
        end
        set_in(6'd0, 1'b1);
        total++;
        if (ifc.state !== 4'd6) begin bad++; $display("FAIL mid_rexec: got %0d want 6", ifc.state); end
        resetN = 1'b0;
        #1;
        total++;
        if (act !== 22'd0) begin bad++; $display("FAIL mid_gate: got %h want 0", act); end
        tick;
        total++;
        if (ifc.state !== 4'd0 || ifc.cycleCount !== 4'd0 || ifc.instrCount !== 4'd0 || act !== 22'd0) begin
            bad++; $display("FAIL mid_reset: got st=%0d cc=%0d ic=%0d ctrl=%h want 0/0/0/0", ifc.state, ifc.cycleCount, ifc.instrCount, act);
        end
        resetN = 1'b1;
        set_in(6'd0, 1'b0);
        total++;
        if (ifc.state !== 4'd0 || ifc.regWrite !== 1'b0 || ifc.instrDone !== 1'b0) begin
            bad++; $display("FAIL mid_resume: got st=%0d rw=%b dn=%b want 0/0/0", ifc.state, ifc.regWrite, ifc.instrDone);
        end
    endtask

    task automatic test_random;
        logic [5:0] ops[13] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3, 6'd8, 6'd12, 6'd13, 6'd10, 6'd63, 6'd17};
        logic [5:0] o;
        logic [21:0] e;
        int path[$];
        int qs[$];
        logic qm[$];
        int cyc = 0;
        int nd = 0;
        do_reset;
        for (int n = 0; n < 40; n++) begin
            o = ops[$urandom_range(0, 12)];
            path = {0, 1};
            case (o)
                6'd0:         path = {path, 6, 7};
                6'd35:        path = {path, 2, 3, 4};
                6'd43:        path = {path, 2, 5};
                6'd4, 6'd5:   path.push_back(8);
                6'd2:         path.push_back(9);
                6'd3:         path.push_back(10);
                6'd8, 6'd12, 6'd13, 6'd10: path = {path, 11, 12};
                default: ;
            endcase
            qs.delete();
            qm.delete();
            foreach (path[k]) begin
                if (path[k] == 0 || path[k] == 3 || path[k] == 5) begin
                    repeat ($urandom_range(0, 4)) begin qs.push_back(path[k]); qm.push_back(1'b0); end
                    qs.push_back(path[k]);
                    qm.push_back(1'b1);
                end else begin
                    qs.push_back(path[k]);
                    qm.push_back(1'($urandom_range(0, 1)));
                end
            end
            foreach (qs[i]) begin
                set_in(o, qm[i]);
                e = exp_ctrl(qs[i], o, qm[i]);
                total++;
                if (ifc.state !== 4'(qs[i]) || act !== e) begin
                    bad++; $display("FAIL rand_op%0d_c%0d: got st=%0d ctrl=%h want %0d/%h", o, i, ifc.state, act, qs[i], e);
                end
                total++;
                if (ifc.cycleCount !== exp_cnt(cyc) || ifc.instrCount !== exp_cnt(nd)) begin
                    bad++; $display("FAIL rand_cnt: got cc=%0d ic=%0d want %0d/%0d", ifc.cycleCount, ifc.instrCount, exp_cnt(cyc), exp_cnt(nd));
                end
                tick;
                cyc++;
                nd += int'(e[0]);
            end
        end
    endtask

    initial begin
        ifc.op = 6'd0;
        ifc.memReady = 1'b0;
        test_reset;
        test_rtype;
        test_lw_wait;
        test_branch;
        test_jal_imm;
        test_illegal;
        test_timeout;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_control_ws.md
Name: mc_control_ws

Overview:
- Multicycle MIPS main control FSM, next generation. Drives the datapath mux/enable signals for fetch, decode and execute.
- Extended over the current controller: memory wait-state handshake (memReady), timeout fault, bne/jal/andi/ori/slti support, proper lw/addi write-back, illegal-opcode and instruction-retired reporting.
- Sits between the instruction register opcode field and the multicycle datapath/memory.

Parameters:
OP_W, 6, opcode width presented on op
TIMEOUT_W, 4, width of memory wait counter; fault after 2^TIMEOUT_W-1 stalled cycles
CNT_W, 32, performance counter width (CTRL_PERF_EN only)

Ports:
clk  in  1  rising-edge clock
resetN  in  1  synchronous, active-low reset
op  in  OP_W  opcode from IR
memReady  in  1  memory completes current access this cycle
pcWrite  out  1  unconditional PC write
pcWriteCond  out  1  PC write if branch condition true
branchNe  out  1  1: condition is ALU-zero false (bne), 0: zero true (beq)
IorD  out  1  0 PC / 1 aluOut as memory address
memRead  out  1  memory read request
memWrite  out  1  memory write request
irWrite  out  1  IR load
memToReg  out  2  00 aluOut, 01 MDR, 10 PC (jal)
regDst  out  2  00 rt, 01 rd, 10 r31
regWrite  out  1  register file write
aluSrcA  out  1  0 PC, 1 A
aluSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
aluOp  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
pcSource  out  2  00 ALU, 01 aluOut, 10 jump target
illegalOp  out  1  one-cycle pulse on unknown opcode
instrDone  out  1  one-cycle pulse on final cycle of each instruction
fault  out  1  sticky memory-timeout flag
state  out  4  current state (debug)
cycleCount  out  CNT_W  cycles since reset
instrCount  out  CNT_W  retired instructions

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMRDWB 4, MEMWR 5, REXEC 6, RWB 7, BRANCH 8, JUMP 9, JAL 10, IMMEXEC 11, IMMWB 12, FAULT 15.
- Reset: resetN low at a clk edge -> state=FETCH, wait counter=0, fault=0, counters=0. While resetN is low, every control output is combinationally forced to 0; state shows the registered value.
- Outputs are Moore, decoded from state. Exceptions: pcWrite/irWrite in FETCH and regWrite in none; write enables in memory states are gated by memReady as listed.
- FETCH: memRead=1, aluSrcB=01, aluOp=000. On memReady=1: irWrite=1, pcWrite=1, go to DECODE. Otherwise hold.
- DECODE: aluSrcB=11, aluOp=000.
  - op 000000 -> REXEC; 100011/101011 -> MEMADDR; 000100/000101 -> BRANCH; 000010 -> JUMP; 000011 -> JAL; 001000/001100/001101/001010 -> IMMEXEC.
  - Any other op -> FETCH with illegalOp=1 that cycle. Illegal ops do not pulse instrDone.
  - Ops are compared zero-extended to OP_W.
- MEMADDR: aluSrcA=1, aluSrcB=10, aluOp=000. lw -> MEMRD; sw -> MEMWR.
- MEMRD: IorD=1, memRead=1. Hold until memReady, then MEMRDWB.
- MEMRDWB: regWrite=1, memToReg=01, regDst=00. instrDone=1. Go to FETCH.
- MEMWR: IorD=1, memWrite=1. Hold until memReady; on memReady, instrDone=1 and go to FETCH.
- REXEC: aluSrcA=1, aluSrcB=00, aluOp=010. Go to RWB.
- RWB: regDst=01, regWrite=1, memToReg=00. instrDone=1. Go to FETCH.
- BRANCH: aluSrcA=1, aluOp=001, pcWriteCond=1, pcSource=01, branchNe=(op==000101). instrDone=1. Go to FETCH.
- JUMP: pcWrite=1, pcSource=10. instrDone=1. Go to FETCH.
- JAL: pcWrite=1, pcSource=10, regWrite=1, regDst=10, memToReg=10. instrDone=1. Go to FETCH.
- IMMEXEC: aluSrcA=1, aluSrcB=10. aluOp: addi 000, andi 011, ori 100, slti 101. Go to IMMWB.
- IMMWB: regDst=00, regWrite=1, memToReg=00. aluOp is held as in IMMEXEC. instrDone=1. Go to FETCH.
- op is sampled in every state; the datapath keeps IR stable between FETCH completion and the next FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEMRD/MEMWR and whenever memReady=1.
  - Increments each stalled cycle in those states.
  - Reaching 2^TIMEOUT_W-1 with memReady=0 -> FAULT next cycle.
  - memReady=1 on the terminal-count cycle wins: normal transition, no fault.
- FAULT: all control outputs 0, fault=1. Exit only by reset.
- A reset asserted mid-instruction abandons it: no instrDone, no further writes.

Optional Feature:
- CTRL_PERF_EN defined:
  - cycleCount increments every cycle resetN=1, including FAULT.
  - instrCount increments on each instrDone.
  - Both wrap modulo 2^CNT_W.
- Not defined: both ports tied to 0, no counter flops.

Test Plan:
- Reset then memReady=1 constantly, op=000000 -> states 0,1,6,7,0. RWB has regWrite=1, regDst=01. instrDone pulses once.
- lw with memReady low 3 cycles in MEMRD -> MEMRD held 4 cycles, memRead=1, IorD=1 throughout. MEMRDWB asserts memToReg=01, regWrite=1.
- op=000101 -> BRANCH with pcWriteCond=1, branchNe=1, aluOp=001, pcSource=01. op=000100 gives branchNe=0.
- op=000011 -> JAL: pcWrite=1, regWrite=1, regDst=10, memToReg=10. op=001101 -> IMMEXEC aluOp=100, then IMMWB regWrite=1.
- op=111111 -> DECODE pulses illegalOp=1, returns to FETCH, instrCount unchanged. memReady=0 for 15 cycles in FETCH (TIMEOUT_W=4) -> FAULT, fault=1, outputs 0 until resetN low.
- CTRL_PERF_EN with CNT_W=4, 20 R-type instructions -> instrCount=4 (wrapped). Reset mid-REXEC -> FETCH, counters=0, no regWrite.
